// File: rtl/async_downcount_pkg.sv
// Shared constants for the async_downcount counter slice.
package async_downcount_pkg;

   localparam int unsigned DOWNCOUNT_WIDTH = 4;
   localparam logic [31:0] DOWNCOUNT_RESET = '0;

endpackage

// File: rtl/async_downcount_stage.sv
// One toggle bit of the down counter; passes a borrow upward when it is zero.
module downcount_stage
   import async_downcount_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic borrow_in,
   output logic q_bit,
   output logic borrow_out
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q_bit <= DOWNCOUNT_RESET[0];
      end else if (borrow_in) begin
         q_bit <= ~q_bit;
      end
   end

   assign borrow_out = borrow_in & ~q_bit;

endmodule

// File: rtl/async_downcount.sv
// Free-running down counter built from chained toggle stages on a single clock.
// Optional registered wrap flag 'borrow' when ASYNC_DOWNCOUNT_BORROW_EN is defined.
module async_downcount
   import async_downcount_pkg::*;
#(
   parameter int unsigned WIDTH = DOWNCOUNT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] q
`ifdef ASYNC_DOWNCOUNT_BORROW_EN
   ,
   output logic             borrow
`endif
);

   logic [WIDTH:0] chain;

   assign chain[0] = 1'b1;

   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      downcount_stage u_stage (
         .clk        (clk),
         .reset      (reset),
         .borrow_in  (chain[i]),
         .q_bit      (q[i]),
         .borrow_out (chain[i+1])
      );
   end

`ifdef ASYNC_DOWNCOUNT_BORROW_EN
   // chain[WIDTH] is high exactly when q is zero; 'running' masks the
   // 0 -> all-ones step that immediately follows reset release.
   logic running;

   always_ff @(posedge clk) begin
      if (reset) begin
         running <= 1'b0;
         borrow  <= 1'b0;
      end else begin
         running <= 1'b1;
         borrow  <= running & chain[WIDTH];
      end
   end
`else
   logic chain_unused;
   assign chain_unused = chain[WIDTH];
`endif

endmodule

// File: tb/tb_async_downcount.sv
// Scoreboard bench for async_downcount at WIDTH 4, 1 and 8 (borrow checked when
// ASYNC_DOWNCOUNT_BORROW_EN is defined).
module tb_async_downcount;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] q4;
   logic [0:0] q1;
   logic [7:0] q8;
`ifdef ASYNC_DOWNCOUNT_BORROW_EN
   logic       b4, b1, b8;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] q4;
      logic [0:0] q1;
      logic [7:0] q8;
      logic       b4;
   } exp_t;

   exp_t sb[$];

   logic [3:0] m4 = '0;
   logic [0:0] m1 = '0;
   logic [7:0] m8 = '0;
   logic       prev_rst = 1'b1;

   always #5 clk = ~clk;

   async_downcount #(.WIDTH(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .q     (q4)
`ifdef ASYNC_DOWNCOUNT_BORROW_EN
      ,
      .borrow(b4)
`endif
   );

   async_downcount #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .q     (q1)
`ifdef ASYNC_DOWNCOUNT_BORROW_EN
      ,
      .borrow(b1)
`endif
   );

   async_downcount #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .q     (q8)
`ifdef ASYNC_DOWNCOUNT_BORROW_EN
      ,
      .borrow(b8)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one edge: push the modelled result, then pop and compare after the edge.
   task automatic step(input logic rst);
      exp_t e;
      reset = rst;
      e.b4  = !rst && !prev_rst && (m4 == 4'd0);
      m4 = rst ? 4'd0 : m4 - 4'd1;
      m1 = rst ? 1'b0 : m1 - 1'b1;
      m8 = rst ? 8'd0 : m8 - 8'd1;
      prev_rst = rst;
      e.q4 = m4;
      e.q1 = m1;
      e.q8 = m8;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_eq("q_w4", 32'(q4), 32'(e.q4));
      check_eq("q_w1", 32'(q1), 32'(e.q1));
      check_eq("q_w8", 32'(q8), 32'(e.q8));
`ifdef ASYNC_DOWNCOUNT_BORROW_EN
      check_eq("borrow_w4", 32'(b4), 32'(e.b4));
`endif
   endtask

   initial begin
      logic [3:0] prev;
      int         guard;

      // Reset held for 3 edges
      step(1'b1);
      step(1'b1);
      step(1'b1);

      // Full period plus wrap
      for (int i = 0; i < 17; i++) step(1'b0);

      // Count to 1010, then reset mid-count
      step(1'b1);
      guard = 0;
      while (m4 != 4'b1010 && guard < 32) begin
         step(1'b0);
         guard++;
      end
      check_eq("reach_1010", 32'(q4), 32'h0000_000a);
      step(1'b1);
      check_eq("mid_reset", 32'(q4), 32'h0);
      step(1'b0);
      check_eq("resume_1111", 32'(q4), 32'h0000_000f);

      // Full 8-bit period
      step(1'b1);
      for (int i = 0; i < 256; i++) step(1'b0);
      check_eq("w8_period", 32'(q8), 32'h0);
      step(1'b0);
      check_eq("w8_wrap", 32'(q8), 32'h0000_00ff);

      // Long run: 20 cycles, decrement-by-one property
      prev = q4;
      for (int i = 0; i < 20; i++) begin
         step(1'b0);
         check_eq("no_x", 32'($isunknown(q4)), 32'h0);
         check_eq("delta", 32'(4'(prev - q4)), 32'h1);
         prev = q4;
      end

      check_eq("sb_empty", 32'(sb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
